// File: rtl/segment_pkg.sv
// Shared encodings for the segment scheduler: FSM states and segment index sizing.
package segment_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam int NUM_SEGMENTS = 6;
    localparam int SEG_IDX_W    = 3;
    localparam logic [SEG_IDX_W-1:0] LAST_SEGMENT = SEG_IDX_W'(NUM_SEGMENTS - 1);

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a delayed copy for rise detection.
module input_sync (
    input  logic clk,
    input  logic async_nreset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [1:0] arm_q, arm_d;

    always_comb begin
        s1_d  = din;
        s2_d  = s1_q;
        s3_d  = s2_q;
        arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            arm_q <= 2'd0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            arm_q <= arm_d;
        end
    end

    // Until s3 holds a genuinely sampled value (three edges after reset), a
    // level held through reset release would look like a fresh rising edge.
    assign level = s2_q;
    assign rise  = s2_q & ~s3_q & (arm_q == 2'd3);

endmodule

// File: rtl/segment_scheduler.sv
// Segment advance scheduler: auto-advance timer, manual step, shadow position and lap count.
module segment_scheduler
    import segment_pkg::*;
#(
    parameter logic [31:0] TICK_BASE = 32'd1000000
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic                 run,
    input  logic                 step,
    input  logic [1:0]           speed,
    output logic                 next_segment_re,
    output logic [SEG_IDX_W-1:0] position,
    output logic [7:0]           lap_count,
    output logic                 running
);

    logic                 run_sync;
    logic                 run_rise_unused;
    logic                 step_level_unused;
    logic                 step_re;
    logic [1:0]           speed_q, speed_d;
    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [SEG_IDX_W-1:0] position_q, position_d;
    logic [7:0]           lap_q, lap_d;
    logic [31:0]          period;
    logic                 terminal;
    logic                 pulse;

    input_sync u_run_sync (
        .clk          (clk),
        .async_nreset (async_nreset),
        .din          (run),
        .level        (run_sync),
        .rise         (run_rise_unused)
    );

    input_sync u_step_sync (
        .clk          (clk),
        .async_nreset (async_nreset),
        .din          (step),
        .level        (step_level_unused),
        .rise         (step_re)
    );

    // speed is a quasi-static select; one flop keeps the pulse decode register-only.
    assign period   = TICK_BASE >> speed_q;
    assign terminal = (cnt_q >= period - 32'd1);
    assign pulse    = (state_q == S_STEP) || ((state_q == S_RUN) && run_sync && terminal);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        speed_d    = speed;
        position_d = position_q;
        lap_d      = lap_q;

        case (state_q)
            S_IDLE: begin
                if (run_sync) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (step_re) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_sync) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (pulse) begin
            if (position_q == LAST_SEGMENT) begin
                position_d = '0;
                lap_d      = lap_q + 8'd1;
            end else begin
                position_d = position_q + SEG_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            speed_q    <= 2'd0;
            position_q <= '0;
            lap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            speed_q    <= speed_d;
            position_q <= position_d;
            lap_q      <= lap_d;
        end
    end

    assign next_segment_re = pulse;
    assign position        = position_q;
    assign lap_count       = lap_q;
    assign running         = (state_q == S_RUN);

endmodule

// File: tb/tb_segment_scheduler.sv
// Directed bench for segment_scheduler with TICK_BASE=8; expected values hand-derived per scenario.
module tb_segment_scheduler;

    logic       clk;
    logic       async_nreset;
    logic       run;
    logic       step;
    logic [1:0] speed;
    logic       next_segment_re;
    logic [2:0] position;
    logic [7:0] lap_count;
    logic       running;

    int errors;
    int checks;

    segment_scheduler #(.TICK_BASE(32'd8)) dut (
        .clk             (clk),
        .async_nreset    (async_nreset),
        .run             (run),
        .step            (step),
        .speed           (speed),
        .next_segment_re (next_segment_re),
        .position        (position),
        .lap_count       (lap_count),
        .running         (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        async_nreset = 1'b0;
        run   = 1'b0;
        step  = 1'b1;
        speed = 2'd0;
        #3;
        checks++;
        if ({next_segment_re, running, position, lap_count} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pulse=%0b run=%0b pos=%0d lap=%0d, want all 0",
                     next_segment_re, running, position, lap_count);
        end
        tick();
        tick();
        async_nreset = 1'b1;
        // step held through release must not produce a manual advance
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (next_segment_re !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL reset_step_held cycle %0d: got pulse=%0b running=%0b, want 0 0",
                         i, next_segment_re, running);
            end
        end
        checks++;
        if (position !== 3'd0) begin
            errors++;
            $display("FAIL reset_step_held_pos: got %0d, want 0", position);
        end
        step = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_run_speed0();
        run = 1'b1;
        for (int i = 1; i <= 51; i++) begin
            tick();
            checks++;
            if (next_segment_re !== ((i >= 10) && ((i - 10) % 8 == 0))) begin
                errors++;
                $display("FAIL run_pulse cycle %0d: got %0b, want %0b",
                         i, next_segment_re, ((i >= 10) && ((i - 10) % 8 == 0)));
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (running !== (i == 3)) begin
                    errors++;
                    $display("FAIL run_latency cycle %0d: running got %0b, want %0b", i, running, (i == 3));
                end
            end
        end
        checks++;
        if (position !== 3'd0 || lap_count !== 8'd1) begin
            errors++;
            $display("FAIL run_six_pulses: got pos=%0d lap=%0d, want pos=0 lap=1", position, lap_count);
        end
    endtask

    task automatic test_speed_change();
        // entry: S_RUN, cnt=0, speed 0
        for (int j = 1; j <= 12; j++) begin
            tick();
            checks++;
            if (next_segment_re !== (j >= 6)) begin
                errors++;
                $display("FAIL speed_change cycle %0d: got %0b, want %0b", j, next_segment_re, (j >= 6));
            end
            if (j == 5) speed = 2'd3;
        end
        speed = 2'd0;
        tick();
        checks++;
        if (position !== 3'd1 || lap_count !== 8'd2 || next_segment_re !== 1'b0) begin
            errors++;
            $display("FAIL speed_change_after: got pos=%0d lap=%0d pulse=%0b, want 1 2 0",
                     position, lap_count, next_segment_re);
        end
    endtask

    task automatic test_stop();
        // entry: S_RUN, cnt=0, speed 0; run_sync falls exactly when cnt=7
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (next_segment_re !== 1'b0) begin
                errors++;
                $display("FAIL stop_no_pulse cycle %0d: got %0b, want 0", k, next_segment_re);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (running !== (k == 7)) begin
                    errors++;
                    $display("FAIL stop_running cycle %0d: got %0b, want %0b", k, running, (k == 7));
                end
            end
            if (k == 5) run = 1'b0;
        end
        checks++;
        if (position !== 3'd1) begin
            errors++;
            $display("FAIL stop_position: got %0d, want 1", position);
        end
    endtask

    task automatic test_manual_step();
        step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (next_segment_re !== (i == 3)) begin
                errors++;
                $display("FAIL step_pulse cycle %0d: got %0b, want %0b", i, next_segment_re, (i == 3));
            end
            if (i == 5) step = 1'b0;
        end
        checks++;
        if (position !== 3'd2 || running !== 1'b0) begin
            errors++;
            $display("FAIL step_position: got pos=%0d running=%0b, want 2 0", position, running);
        end
    endtask

    task automatic test_simultaneous();
        run  = 1'b1;
        step = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (next_segment_re !== (i == 10 || i == 18 || i == 26)) begin
                errors++;
                $display("FAIL simul_pulse cycle %0d: got %0b, want %0b",
                         i, next_segment_re, (i == 10 || i == 18 || i == 26));
            end
            if (i == 3 || i == 30) begin
                checks++;
                if (running !== (i == 3)) begin
                    errors++;
                    $display("FAIL simul_running cycle %0d: got %0b, want %0b", i, running, (i == 3));
                end
            end
            if (i == 27) begin
                checks++;
                if (position !== 3'd5 || lap_count !== 8'd2) begin
                    errors++;
                    $display("FAIL simul_position: got pos=%0d lap=%0d, want 5 2", position, lap_count);
                end
                run = 1'b0;
            end
            if (i == 2 || i == 15 || i == 23) step = 1'b0;
            if (i == 12 || i == 19) step = 1'b1;
        end
    endtask

    task automatic test_reset_midrun();
        run = 1'b1;
        for (int i = 1; i <= 10; i++) tick();
        checks++;
        if (next_segment_re !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: got pulse=%0b running=%0b, want 1 1", next_segment_re, running);
        end
        #2;
        async_nreset = 1'b0;
        #1;
        checks++;
        if ({next_segment_re, running, position, lap_count} !== 13'd0) begin
            errors++;
            $display("FAIL midrun_reset: got pulse=%0b run=%0b pos=%0d lap=%0d, want all 0",
                     next_segment_re, running, position, lap_count);
        end
        run = 1'b0;
        tick();
        tick();
        async_nreset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (next_segment_re !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL midrun_release cycle %0d: got pulse=%0b running=%0b, want 0 0",
                         i, next_segment_re, running);
            end
        end
    endtask

    task automatic test_laps();
        int pcount;
        bit done;
        pcount = 0;
        done   = 1'b0;
        speed  = 2'd3;
        tick();
        run = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (pcount == 1530) begin
                checks++;
                if (position !== 3'd0 || lap_count !== 8'd255) begin
                    errors++;
                    $display("FAIL laps_255: got pos=%0d lap=%0d, want 0 255", position, lap_count);
                end
            end
            if (pcount == 1536) begin
                checks++;
                if (position !== 3'd0 || lap_count !== 8'd0) begin
                    errors++;
                    $display("FAIL laps_wrap: got pos=%0d lap=%0d, want 0 0", position, lap_count);
                end
                done = 1'b1;
            end
            if (next_segment_re === 1'b1) pcount++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL laps_timeout: got %0d pulses, want 1536", pcount);
        end
        run   = 1'b0;
        speed = 2'd0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_run_speed0();
        test_speed_change();
        test_stop();
        test_manual_step();
        test_simultaneous();
        test_reset_midrun();
        test_laps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
